// File: rtl/mem_pkg.sv
// mem_pkg: shared opcodes, FSM states and constants for the memory stage
package mem_pkg;
    localparam logic [4:0]  OP_LW = 5'b01000;
    localparam logic [4:0]  OP_SW = 5'b00111;
    localparam logic [31:0] NOP   = 32'b0;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/dmem_port.sv
// dmem_port: request registers, wait counter and timeout detection for the data memory
module dmem_port #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 12
) (
    input  logic          clock,
    input  logic          clrn,
    input  logic          start,
    input  logic          busy,
    input  logic          clear,
    input  logic [AW-1:0] addr_in,
    input  logic          we_in,
    input  logic [31:0]   wdata_in,
    input  logic          dmem_ack,
    input  logic [31:0]   dmem_rdata,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    output logic          done,
    output logic          aborted,
    output logic [31:0]   rdata_q
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          expired;
    assign expired  = cnt == CW'(TIMEOUT - 1);
    assign dmem_req = busy;
    assign done     = busy && (dmem_ack || expired);
    // capture the request, count busy cycles, latch the response or abort on expiry
    always_ff @(posedge clock) begin
        if (!clrn) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            cnt        <= '0;
            aborted    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (start) begin
                dmem_we    <= we_in;
                dmem_addr  <= addr_in;
                dmem_wdata <= wdata_in;
            end
            if (busy) begin
                cnt <= cnt + 1'b1;
                if (dmem_ack)
                    rdata_q <= dmem_we ? 32'b0 : dmem_rdata;
                else if (expired) begin
                    aborted <= 1'b1;
                    rdata_q <= 32'b0;
                end
            end
            if (clear) begin
                cnt     <= '0;
                aborted <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage issuing loads/stores and stalling upstream while busy
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int AW      = 12
) (
    input  logic          clock,
    input  logic          clrn,
    input  logic          valid_in,
    input  logic [31:0]   o_in,
    input  logic [31:0]   ir_in,
    input  logic [31:0]   b_in,
    input  logic [31:0]   pc_jal_in,
    input  logic          jal_in,
    input  logic          exception_in,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_ack,
    input  logic [31:0]   dmem_rdata,
    output logic [31:0]   o_out,
    output logic [31:0]   ir_out,
    output logic [31:0]   d_out,
    output logic [31:0]   pc_jal_out,
    output logic          jal_out,
    output logic          exception_out,
    output logic          stall
);
    state_t      state;
    logic [31:0] o_q, ir_q, pc_jal_q, rdata_q;
    logic        jal_q, done, aborted;
    logic        is_mem, in_range, start, pass, resp;
    assign is_mem   = ir_in[31:27] == OP_LW || ir_in[31:27] == OP_SW;
    assign in_range = o_in[31:AW] == '0;
    assign start    = state == IDLE && valid_in && is_mem && !exception_in && in_range;
    assign pass     = state == IDLE && !start;
    assign resp     = state == RESP;
    dmem_port #(.TIMEOUT(TIMEOUT), .AW(AW)) u_port (
        .clock(clock), .clrn(clrn), .start(start), .busy(state == BUSY), .clear(resp),
        .addr_in(o_in[AW-1:0]), .we_in(ir_in[31:27] == OP_SW), .wdata_in(b_in),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .done(done), .aborted(aborted), .rdata_q(rdata_q)
    );
    // sequence IDLE -> BUSY -> RESP and hold the instruction while memory works
    always_ff @(posedge clock) begin
        if (!clrn) begin
            state    <= IDLE;
            o_q      <= '0;
            ir_q     <= NOP;
            pc_jal_q <= '0;
            jal_q    <= 1'b0;
        end else begin
            state <= state == IDLE ? (start ? BUSY : IDLE) : state == BUSY ? (done ? RESP : BUSY) : IDLE;
            if (start) begin
                o_q      <= o_in;
                ir_q     <= ir_in;
                pc_jal_q <= pc_jal_in;
                jal_q    <= jal_in;
            end
        end
    end
    // pass-through in IDLE, captured result in RESP, bubble otherwise
    always_comb begin
        o_out         = pass ? o_in : resp ? o_q : 32'b0;
        ir_out        = pass ? (valid_in ? ir_in : NOP) : resp ? ir_q : NOP;
        d_out         = resp ? rdata_q : 32'b0;
        pc_jal_out    = pass ? pc_jal_in : resp ? pc_jal_q : 32'b0;
        jal_out       = pass ? valid_in && jal_in : resp && jal_q;
        exception_out = pass ? valid_in && (exception_in || (is_mem && !in_range)) : resp && aborted;
        stall         = start || state == BUSY;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random load/store checks against a simple memory reference
module tb_mem_stage;
    localparam int TIMEOUT = 16;
    localparam int AW      = 12;
    localparam logic [4:0] LW = 5'b01000;
    localparam logic [4:0] SW = 5'b00111;
    logic          clock = 1'b0;
    logic          clrn, valid_in, jal_in, exception_in, dmem_ack;
    logic [31:0]   o_in, ir_in, b_in, pc_jal_in, dmem_rdata;
    logic          dmem_req, dmem_we, jal_out, exception_out, stall;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata, o_out, ir_out, d_out, pc_jal_out;
    logic [31:0]   env_mem [logic [AW-1:0]];
    logic [31:0]   ref_mem [logic [AW-1:0]];
    int            n_assert = 0;
    int            n_fail = 0;

    mem_stage #(.TIMEOUT(TIMEOUT), .AW(AW)) dut (
        .clock(clock), .clrn(clrn), .valid_in(valid_in), .o_in(o_in), .ir_in(ir_in),
        .b_in(b_in), .pc_jal_in(pc_jal_in), .jal_in(jal_in), .exception_in(exception_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .o_out(o_out), .ir_out(ir_out), .d_out(d_out), .pc_jal_out(pc_jal_out),
        .jal_out(jal_out), .exception_out(exception_out), .stall(stall)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] dflt(input logic [AW-1:0] a);
        return {20'hC0DE0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one instruction; lat = BUSY cycle (1-based) on which memory acks, 0 = never
    task automatic run_op(input logic [4:0] op, input logic [31:0] o, input logic [31:0] b,
                          input int lat, input logic exc, input logic valid);
        logic [31:0]   ir, pc, exp_d;
        logic          jl, memop, inr, ab;
        logic [AW-1:0] a;
        int            n, reqcnt, stallcnt;
        ir = {op, 27'($urandom)};
        pc = $urandom;
        jl = 1'($urandom);
        a  = o[AW-1:0];
        @(negedge clock);
        valid_in = valid; o_in = o; ir_in = ir; b_in = b; pc_jal_in = pc; jal_in = jl;
        exception_in = exc; dmem_ack = 1'b0;
        #1;
        memop = op == LW || op == SW;
        inr   = o[31:AW] == 0;
        if (!(valid && !exc && memop && inr)) begin
            chk("pt_o", o_out, o);
            chk("pt_ir", ir_out, valid ? ir : 32'b0);
            chk("pt_d", d_out, 32'b0);
            chk("pt_pc", pc_jal_out, pc);
            chk("pt_jal", 32'(jal_out), 32'(valid && jl));
            chk("pt_exc", 32'(exception_out), 32'(valid && (exc || (memop && !inr))));
            chk("pt_stall_req", {stall, dmem_req}, 32'b0);
            return;
        end
        chk("detect_stall", 32'(stall), 32'd1);
        chk("detect_bubble", o_out | ir_out | d_out | pc_jal_out | {jal_out, exception_out}, 32'b0);
        n  = (lat >= 1 && lat <= TIMEOUT) ? lat : TIMEOUT;
        ab = n != lat;
        exp_d = (op == LW && !ab) ? (ref_mem.exists(a) ? ref_mem[a] : dflt(a)) : 32'b0;
        if (op == SW && !ab) ref_mem[a] = b;
        reqcnt = 0;
        stallcnt = 1;
        for (int c = 0; c < TIMEOUT + 4; c++) begin
            @(negedge clock);
            dmem_ack = 1'b0;
            #1;
            if (dmem_req !== 1'b1) break;
            reqcnt++;
            stallcnt += int'(stall);
            chk("busy_req", {dmem_we, 20'(dmem_addr)}, {op == SW, 20'(a)});
            chk("busy_wdata", dmem_wdata, b);
            chk("busy_bubble", o_out | ir_out | d_out | pc_jal_out | {jal_out, exception_out}, 32'b0);
            dmem_ack   = reqcnt == lat;
            dmem_rdata = dmem_ack ? (env_mem.exists(dmem_addr) ? env_mem[dmem_addr] : dflt(dmem_addr)) : $urandom;
            if (dmem_ack && dmem_we) env_mem[dmem_addr] = dmem_wdata;
        end
        chk("busy_cycles", reqcnt, n);
        chk("stall_cycles", stallcnt, n + 1);
        chk("resp_stall", 32'(stall), 32'b0);
        chk("resp_d", d_out, exp_d);
        chk("resp_exc", 32'(exception_out), 32'(ab));
        chk("resp_ir", ir_out, ir);
        chk("resp_o", o_out, o);
        chk("resp_pc", pc_jal_out, pc);
        chk("resp_jal", 32'(jal_out), 32'(jl));
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] addr;
        clrn = 1'b0; valid_in = 1'b1; o_in = 32'h77; ir_in = 32'b0; b_in = 32'b0;
        pc_jal_in = 32'h40; jal_in = 1'b0; exception_in = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_req_we", {dmem_req, dmem_we, stall}, 32'b0);
        chk("rst_addr", 32'(dmem_addr), 32'b0);
        chk("rst_wdata", dmem_wdata, 32'b0);
        chk("rst_pass_o", o_out, 32'h77);
        clrn = 1'b1;
        env_mem[12'h010] = 32'hDEAD_BEEF;
        ref_mem[12'h010] = 32'hDEAD_BEEF;
        run_op(5'b00000, 32'd5, 32'd0, 0, 1'b0, 1'b1);
        run_op(LW, 32'h010, 32'd0, 1, 1'b0, 1'b1);
        run_op(SW, 32'h020, 32'h1234_5678, 3, 1'b0, 1'b1);
        run_op(LW, 32'h020, 32'd0, 2, 1'b0, 1'b1);
        run_op(LW, 32'h030, 32'd0, 0, 1'b0, 1'b1);
        run_op(LW, 32'h0000_1000, 32'd0, 1, 1'b0, 1'b1);
        run_op(SW, 32'h8000_0004, 32'd9, 1, 1'b0, 1'b1);
        run_op(LW, 32'h040, 32'd0, TIMEOUT, 1'b0, 1'b1);
        run_op(LW, 32'h040, 32'd0, TIMEOUT + 1, 1'b0, 1'b1);
        run_op(LW, 32'h050, 32'd0, 1, 1'b1, 1'b1);
        run_op(SW, 32'h050, 32'd3, 1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       op = LW;
                1:       op = SW;
                default: op = 5'($urandom);
            endcase
            addr = ($urandom_range(0, 9) == 0) ? $urandom : {28'b0, 4'($urandom)};
            run_op(op, addr, $urandom, $urandom_range(0, TIMEOUT + 2), $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) != 0);
        end
        @(negedge clock);
        valid_in = 1'b1; o_in = 32'h060; ir_in = {LW, 27'b0}; exception_in = 1'b0; dmem_ack = 1'b0;
        #1;
        chk("mid_detect", 32'(stall), 32'd1);
        @(negedge clock);
        #1;
        chk("mid_busy1", 32'(dmem_req), 32'd1);
        @(negedge clock);
        clrn = 1'b0;
        #1;
        chk("mid_busy2", 32'(dmem_req), 32'd1);
        @(negedge clock);
        clrn = 1'b1; valid_in = 1'b0; o_in = 32'h99; dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("mid_rst_req_stall", {dmem_req, stall}, 32'b0);
        chk("mid_rst_addr", 32'(dmem_addr), 32'b0);
        chk("mid_rst_pass", o_out, 32'h99);
        @(negedge clock);
        #1;
        chk("late_ack_ignored", {dmem_req, stall, exception_out}, 32'b0);
        chk("late_ack_d", d_out, 32'b0);
        dmem_ack = 1'b0;
        run_op(LW, 32'h010, 32'd0, 2, 1'b0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, sitting between the EX/MEM latch and `latch_4` (MEM/WB). It decodes the instruction in flight and performs loads and stores against a variable-latency data memory over a req/ack handshake. It freezes the upstream pipeline while an access is outstanding and delivers `o/ir/d/pc_jal/jal/exception` to `latch_4`. A bubble is presented to `latch_4` while the stage is busy.

## Interface
Parameters:
- `TIMEOUT`, 16 — maximum cycles `dmem_req` may wait for `dmem_ack` before the access is aborted.
- `AW`, 12 — data-memory word-address width.

Ports:
- `clock` in 1 — single clock; all state updates on its rising edge.
- `clrn` in 1 — reset, synchronous, active-low.
- `valid_in` in 1 — the EX/MEM latch holds a real instruction; 0 means bubble.
- `o_in` in 32 — ALU result; the effective word address for `lw`/`sw`.
- `ir_in` in 32 — instruction word.
- `b_in` in 32 — store data (the rd register value).
- `pc_jal_in` in 32, `jal_in` in 1, `exception_in` in 1 — sideband from EX.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out AW, `dmem_wdata` out 32 — memory request.
- `dmem_ack` in 1, `dmem_rdata` in 32 — memory response; `dmem_rdata` is valid while `dmem_ack`=1.
- `o_out` out 32, `ir_out` out 32, `d_out` out 32, `pc_jal_out` out 32, `jal_out` out 1, `exception_out` out 1 — to the `latch_4` inputs.
- `stall` out 1 — holds PC and latches 1–3; `latch_4` stays enabled.

## Operation
- Opcode is `ir_in[31:27]`: `lw`=01000, `sw`=00111; every other opcode is a non-memory op.
- An address is in range iff `o_in[31:AW]`==0.
- FSM states: IDLE, BUSY, RESP.
- **IDLE, pass-through:** applies when `valid_in`=0, the op is non-memory, or `exception_in`=1.
  - Outputs equal the inputs combinationally; `d_out`=0; `stall`=0.
  - When `valid_in`=0, `ir_out`=0, `jal_out`=0 and `exception_out`=0.
- **IDLE, memory op with out-of-range address:** no request is issued. Pass-through applies with `exception_out`=1 and `d_out`=0.
- **IDLE, memory op with valid address:**
  - Capture `o/ir/b/pc_jal/jal` and the we flag (1 for `sw`).
  - Assert `stall`=1 combinationally.
  - Present a bubble: all `*_out`=0.
  - Next state is BUSY.
- **BUSY:**
  - `dmem_req`=1, with `dmem_addr`=captured `o[AW-1:0]`, `dmem_we`=captured we, and `dmem_wdata`=captured b, all held stable.
  - `stall`=1; bubble on the outputs.
  - A wait counter increments each BUSY cycle.
  - On `dmem_ack`=1: capture `dmem_rdata` (forced to 0 for stores) and go to RESP.
  - If the counter reaches `TIMEOUT`-1 with no ack: abort, set the abort flag and the captured data to 0, and go to RESP.
- **RESP:**
  - `dmem_req`=0 and `stall`=0.
  - Outputs come from the captured registers: `d_out`=captured data, `exception_out`=abort flag.
  - Next state is IDLE; the counter and abort flag are cleared.
- `dmem_ack` outside BUSY is ignored.

## Timing
- Reset (`clrn`=0 at an edge): state goes to IDLE; counter, abort flag and all capture registers go to 0.
  - After reset, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0 and `stall`=0.
  - `*_out` are pass-through from the inputs.
  - Reset in BUSY drops `dmem_req` on the next edge; the abandoned access is not retried.
- Non-memory op: zero-cycle combinational latency; `latch_4` captures it at the same edge.
- Memory op with ack on the first BUSY cycle: IDLE (detect) → BUSY → RESP, so `stall` is high for exactly 2 cycles.
- General case: `stall` is high for 1 + (BUSY cycles) cycles.
- Upstream inputs must be held stable while `stall`=1; the block does not rely on this after capture.
- Ack on the same cycle the counter expires: the ack wins; no exception.
- The instruction behind a memory op enters IDLE in the cycle after RESP. There are no back-to-back bubbles beyond the BUSY cycles.

## Structure
- Shared package `mem_pkg`:
  - opcode constants `OP_LW`, `OP_SW`;
  - state enum {IDLE, BUSY, RESP};
  - a `NOP` instruction constant (32'b0).
- One sub-module, `dmem_port`:
  - holds the request registers, the wait counter and the timeout compare;
  - outputs `done`, `aborted` and `rdata_q`.
- `mem_stage` owns the FSM and the output muxing.

## Test plan
- **Pass-through:** `add`, `ir`=32'h0000_0000|op 00000, `o_in`=5 → same cycle `o_out`=5, `d_out`=0, `stall`=0, `dmem_req` never 1.
- **Zero-wait load:** `lw` with `o_in`=12'h010 and the memory acking in the first BUSY cycle with 32'hDEAD_BEEF.
  - Required: `stall` high 2 cycles; `dmem_addr`=12'h010, `dmem_we`=0.
  - In RESP, `d_out`=32'hDEAD_BEEF, `ir_out`=the `lw` word, `exception_out`=0.
- **Store with 3-cycle ack:** `sw` with `o_in`=12'h020, `b_in`=32'h1234_5678.
  - Required: `dmem_we`=1 and the `dmem_wdata` value held for 3 BUSY cycles; `stall` high 4 cycles; RESP has `d_out`=0.
- **Timeout:** `lw` with no ack.
  - Required: `dmem_req` high exactly `TIMEOUT` (16) cycles, then RESP with `exception_out`=1, `d_out`=0.
- **Out-of-range:** `lw` with `o_in`=32'h0000_1000 → no `dmem_req`, `exception_out`=1 the same cycle, `stall`=0.
- **Reset mid-access:** `clrn`=0 in the 2nd BUSY cycle → next cycle `dmem_req`=0, `stall`=0, state IDLE; a late `dmem_ack` is ignored.
